uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter core between NREQ byte requesters.
//  Picks a requester round-robin, hands its byte to the core with a tx_start pulse, and tracks the core's busy flag until the frame ends.
//  Sits between the producer blocks and the UART tx core inside top.
// PARAMETERS
//  NREQ        4   number of requesters (2..8; need not be a power of 2)
//  DATA_W      8   byte width per requester
//  IDX_W       2   width of owner index; must satisfy 2**IDX_W >= NREQ
//  TIMEOUT_CYC 15  cycles to wait for tx_busy rise (used only with UART_ARB_TIMEOUT_EN)
// PORTS
//  clk       in   1             system clock, rising edge
//  rst       in   1             asynchronous, active-low reset
//  req       in   NREQ          req[i]=1: requester i has a byte pending
//  req_data  in   NREQ*DATA_W   byte i at [i*DATA_W +: DATA_W]
//  gnt       out  NREQ          one-hot, 1-cycle pulse: byte of requester i accepted
//  tx_start  out  1             1-cycle pulse to tx core, same cycle as gnt
//  tx_data   out  DATA_W        byte to tx core; held stable from tx_start until the frame ends
//  tx_busy   in   1             tx core frame in progress
//  owner     out  IDX_W         index of current/last winner
//  active    out  1             1 in every state except IDLE
//  done      out  1             1-cycle pulse: frame finished (tx_busy fell)
//  err       out  1             1-cycle pulse: start timeout (feature builds only)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; gnt, tx_start, active, done, err = 0; tx_data=0, owner=0, rr pointer=0.
//  Taking rst low mid-frame aborts the frame immediately. The tx core is not notified.
//  FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
//  IDLE: if |req && !tx_busy:
//    - winner = first set req[k], scanning k = ptr, ptr+1, ... with wrap to 0 after NREQ-1.
//    - Latch req_data[winner] into tx_data and winner into owner; go to LAUNCH.
//    - If tx_busy=1 in IDLE, grant nothing and stay in IDLE.
//  LAUNCH (exactly 1 cycle): tx_start=1, gnt[owner]=1; go to WAIT_BUSY.
//    - Requesters hold req and data until gnt. At gnt they drop req or present the next byte.
//    - A req dropped before gnt is not served. The arbiter makes no commitment before the LAUNCH cycle.
//  WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE.
//  WAIT_DONE: stay until tx_busy=0, then:
//    - pulse done for 1 cycle;
//    - ptr = (owner==NREQ-1) ? 0 : owner+1;
//    - go to IDLE.
//  Latency: req seen in IDLE at edge N gives tx_start/gnt during cycle N+1.
//    - Minimum spacing between grants = frame length + 3 cycles.
//  Changes to req or req_data after the IDLE decision have no effect on the current frame.
//  At most one gnt bit is ever set; gnt and tx_start are never high outside LAUNCH.
//  A single requester with req held high is re-granted after each done (no starvation and no lockout).
//  If tx_busy is already 1 in the LAUNCH cycle, WAIT_BUSY exits on the next edge.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined:
//    - A counter runs in WAIT_BUSY, cleared on entry.
//    - If tx_busy is still 0 after TIMEOUT_CYC cycles: pulse err, go to IDLE, ptr = owner+1 (wrapped).
//    - done is not pulsed in this case.
//  UART_ARB_TIMEOUT_EN undefined:
//    - WAIT_BUSY waits indefinitely; no counter logic.
//    - err is tied to 0.
// TESTING
//  T1 reset:
//    - rst=0 with req=4'b1111 -> all outputs 0, state IDLE.
//    - Release rst; req[0], data 8'hA5 -> tx_start+gnt=4'b0001 next cycle, tx_data=8'hA5.
//  T2 round-robin:
//    - req=4'b1011 held, core model busy for 10 cycles per frame.
//    - -> grant order 0,1,3,0; done pulses 4 times.
//  T3 busy blocking:
//    - tx_busy=1 in IDLE with req=4'b0100 -> no gnt.
//    - Drop busy -> gnt=4'b0100 one cycle later.
//  T4 data hold:
//    - Change req_data[2] from 8'h3C to 8'hFF after gnt -> tx_data stays 8'h3C until done.
//  T5 mid-frame reset:
//    - rst=0 in WAIT_DONE -> active=0 and tx_data=0 immediately.
//    - After release, ptr=0: req=4'b1001 grants 0.
//  T6 (UART_ARB_TIMEOUT_EN):
//    - Core never raises busy -> err pulse 15 cycles after WAIT_BUSY entry, no done.
//    - Next grant goes to the following requester.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter core between NREQ byte requesters.
// Round-robin pick in IDLE, one-cycle tx_start/gnt launch, then follows tx_busy
// until the frame ends. Optional build macro UART_ARB_TIMEOUT_EN adds a start
// timeout: if tx_busy never rises, err pulses and the arbiter moves on.

module uart_arb_lane #(
    parameter int IDX_W = 2,
    parameter int IDX   = 0
) (
    input  logic             req,
    input  logic [IDX_W-1:0] ptr,
    output logic             hi
);
    // Requester sits at or after the rr pointer: first leg of the wrapped scan.
    assign hi = req && (IDX_W'(IDX) >= ptr);
endmodule

module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int DATA_W      = 8,
    parameter int IDX_W       = 2,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        gnt,
    output logic                   tx_start,
    output logic [DATA_W-1:0]      tx_data,
    input  logic                   tx_busy,
    output logic [IDX_W-1:0]       owner,
    output logic                   active,
    output logic                   done,
    output logic                   err
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                        state;
    logic [IDX_W-1:0]              ptr;
    logic [IDX_W-1:0]              win;
    logic [IDX_W-1:0]              nxt;
    logic [NREQ-1:0]               hi;
    logic [NREQ-1:0][DATA_W-1:0]   bytes;

    assign bytes = req_data;

    genvar i;
    generate
        for (i = 0; i < NREQ; i++) begin : g_lane
            uart_arb_lane #(.IDX_W(IDX_W), .IDX(i)) u_lane (
                .req (req[i]),
                .ptr (ptr),
                .hi  (hi[i])
            );
        end
    endgenerate

    // Lowest requester at/after ptr wins; if none, wrap to the lowest overall.
    always_comb begin
        win = '0;
        for (int k = NREQ-1; k >= 0; k--)
            if (req[k]) win = IDX_W'(k);
        for (int k = NREQ-1; k >= 0; k--)
            if (hi[k]) win = IDX_W'(k);
    end

    // Pointer moves to the slot after the one just served.
    assign nxt = (owner == IDX_W'(NREQ-1)) ? '0 : owner + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tcnt;
`else
    assign err = 1'b0;
`endif

    // Arbiter FSM; all outputs registered, pulses cleared by default each cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            tx_data  <= '0;
            gnt      <= '0;
            tx_start <= 1'b0;
            active   <= 1'b0;
            done     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            err      <= 1'b0;
            tcnt     <= '0;
`endif
        end else begin
            gnt      <= '0;
            tx_start <= 1'b0;
            done     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            err      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|req && !tx_busy) begin
                        owner    <= win;
                        tx_data  <= bytes[win];
                        gnt      <= NREQ'(1) << win;
                        tx_start <= 1'b1;
                        active   <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (tcnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        err    <= 1'b1;
                        ptr    <= nxt;
                        active <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        done   <= 1'b1;
                        ptr    <= nxt;
                        active <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic checked
// against a round-robin reference model. Define UART_ARB_TIMEOUT_EN to also
// exercise the start timeout.

module tb_uart_tx_arbiter;
    localparam int NREQ = 4, DATA_W = 8, IDX_W = 2, TIMEOUT_CYC = 15;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NREQ-1:0]             req;
    logic [NREQ-1:0][DATA_W-1:0] dat;
    logic [NREQ-1:0]             gnt;
    logic                        tx_start;
    logic [DATA_W-1:0]           tx_data;
    logic                        tx_busy;
    logic [IDX_W-1:0]            owner;
    logic                        active, done, err;

    int  n_chk = 0, n_pass = 0;
    int  bad = 0;
    int  mptr = 0;
    bit  core_auto = 1'b1;
    bit  man_busy = 1'b0;
    int  frame_len = 5;
    int  rem = 0;

    uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .IDX_W(IDX_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(dat), .gnt(gnt), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .owner(owner), .active(active), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // tx core model: busy for frame_len cycles starting the cycle after tx_start
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!core_auto) tx_busy = man_busy;
            else if (rem > 0) begin rem--; tx_busy = (rem != 0); end
            else begin tx_busy = 1'b0; if (tx_start) rem = frame_len + 1; end
        end
    end

    // structural watch: gnt one-hot-or-zero and always paired with tx_start
    initial begin
        forever begin
            @(negedge clk);
            if (!$onehot0(gnt) || (tx_start != (gnt != '0))) bad++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

    // reference: first requester scanning from p upward with wrap
    function automatic int rr_pick(int p, logic [NREQ-1:0] m);
        for (int s = 0; s < NREQ; s++)
            if (m[(p + s) % NREQ]) return (p + s) % NREQ;
        return -1;
    endfunction

    task automatic wait_gnt(output bit ok, output int n, output int nd);
        ok = 0; n = 0; nd = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            n++;
            if (done) nd++;
            if (gnt != '0) begin ok = 1; return; end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) begin ok = 1; return; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req = '0; core_auto = 1'b1; man_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; mptr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 4'b1111; core_auto = 1'b1; frame_len = 5;
        for (int r = 0; r < NREQ; r++) dat[r] = DATA_W'($urandom);
        repeat (3) @(negedge clk);
        n_chk++; if (gnt !== '0) $display("FAIL rst_gnt got %b want 0", gnt); else n_pass++;
        n_chk++; if (tx_start !== 1'b0) $display("FAIL rst_tx_start got %b want 0", tx_start); else n_pass++;
        n_chk++; if (active !== 1'b0) $display("FAIL rst_active got %b want 0", active); else n_pass++;
        n_chk++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL rst_pulses got %b%b want 00", done, err); else n_pass++;
        n_chk++; if (tx_data !== '0 || owner !== '0) $display("FAIL rst_data got %h/%0d want 0/0", tx_data, owner); else n_pass++;
        req = 4'b0001; dat[0] = 8'hA5; rst = 1'b1;
        @(negedge clk);
        n_chk++; if (gnt !== 4'b0001 || tx_start !== 1'b1) $display("FAIL t1_launch got %b/%b want 0001/1", gnt, tx_start); else n_pass++;
        n_chk++; if (tx_data !== 8'hA5) $display("FAIL t1_data got %h want a5", tx_data); else n_pass++;
        req = '0;
        begin
            bit ok;
            wait_done(ok);
            if (!ok) begin n_chk++; $display("FAIL t1_done got timeout want done"); end
        end
        mptr = 1;
    endtask

    task automatic test_round_robin();
        bit ok; int n, nd, w, dsum;
        logic [NREQ-1:0] eg;
        do_reset();
        for (int r = 0; r < NREQ; r++) dat[r] = DATA_W'($urandom);
        frame_len = 10; req = 4'b1011; dsum = 0;
        for (int g = 0; g < 4; g++) begin
            wait_gnt(ok, n, nd);
            dsum += nd;
            if (!ok) begin n_chk++; $display("FAIL t2_wait got timeout want grant %0d", g); end
            w = rr_pick(mptr, 4'b1011);
            eg = '0; eg[w] = 1'b1;
            n_chk++; if (gnt !== eg) $display("FAIL t2_gnt%0d got %b want %b", g, gnt, eg); else n_pass++;
            n_chk++; if (tx_data !== dat[w]) $display("FAIL t2_data%0d got %h want %h", g, tx_data, dat[w]); else n_pass++;
            if (g > 0) begin
                n_chk++; if (n != frame_len + 3) $display("FAIL t2_spacing got %0d want %0d", n, frame_len + 3); else n_pass++;
            end
            mptr = (w + 1) % NREQ;
            if (g == 3) req = '0;
        end
        wait_done(ok);
        if (ok) dsum++;
        n_chk++; if (dsum != 4) $display("FAIL t2_done_count got %0d want 4", dsum); else n_pass++;
    endtask

    task automatic test_busy_block_and_hold();
        int seen; bit ok;
        core_auto = 1'b0; man_busy = 1'b1;
        repeat (2) @(negedge clk);
        req = 4'b0100; dat[2] = 8'h3C; seen = 0;
        repeat (5) begin @(negedge clk); if (gnt != '0) seen++; end
        n_chk++; if (seen != 0) $display("FAIL t3_blocked got %0d grants want 0", seen); else n_pass++;
        man_busy = 1'b0;
        @(negedge clk);
        n_chk++; if (gnt !== '0) $display("FAIL t3_early got %b want 0000", gnt); else n_pass++;
        @(negedge clk);
        n_chk++; if (gnt !== 4'b0100) $display("FAIL t3_gnt got %b want 0100", gnt); else n_pass++;
        n_chk++; if (tx_data !== 8'h3C) $display("FAIL t3_data got %h want 3c", tx_data); else n_pass++;
        dat[2] = 8'hFF; req = '0; man_busy = 1'b1; seen = 0;
        repeat (6) begin @(negedge clk); if (tx_data !== 8'h3C || active !== 1'b1) seen++; end
        n_chk++; if (seen != 0) $display("FAIL t4_hold got %0d bad cycles want 0", seen); else n_pass++;
        man_busy = 1'b0;
        wait_done(ok);
        if (!ok) begin n_chk++; $display("FAIL t4_done got timeout want done"); end
        n_chk++; if (tx_data !== 8'h3C || owner !== 2'd2) $display("FAIL t4_at_done got %h/%0d want 3c/2", tx_data, owner); else n_pass++;
        mptr = 3;
    endtask

    task automatic test_mid_reset();
        bit ok; int n, nd;
        req = 4'b0010; dat[1] = 8'h80 | DATA_W'($urandom);
        wait_gnt(ok, n, nd);
        if (!ok) begin n_chk++; $display("FAIL t5_wait got timeout want grant"); end
        n_chk++; if (gnt !== 4'b0010) $display("FAIL t5_gnt got %b want 0010", gnt); else n_pass++;
        req = '0; man_busy = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (active !== 1'b1) $display("FAIL t5_active got %b want 1", active); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_chk++; if (active !== 1'b0 || tx_data !== '0 || owner !== '0) $display("FAIL t5_abort got %b/%h/%0d want 0/00/0", active, tx_data, owner); else n_pass++;
        @(negedge clk);
        man_busy = 1'b0; core_auto = 1'b1; frame_len = 4;
        req = 4'b1001; dat[0] = DATA_W'($urandom); dat[3] = DATA_W'($urandom);
        rst = 1'b1; mptr = 0;
        wait_gnt(ok, n, nd);
        if (!ok) begin n_chk++; $display("FAIL t5_wait2 got timeout want grant"); end
        n_chk++; if (gnt !== 4'b0001 || tx_data !== dat[0]) $display("FAIL t5_regrant got %b/%h want 0001/%h", gnt, tx_data, dat[0]); else n_pass++;
        req = '0;
        wait_done(ok);
        if (!ok) begin n_chk++; $display("FAIL t5_done got timeout want done"); end
        mptr = 1;
    endtask

    task automatic test_random();
        bit ok; int n, nd, w;
        logic [NREQ-1:0] m, eg;
        logic [DATA_W-1:0] eb;
        core_auto = 1'b1;
        for (int t = 0; t < 40; t++) begin
            frame_len = $urandom_range(1, 6);
            m = NREQ'($urandom_range(1, 15));
            for (int r = 0; r < NREQ; r++) dat[r] = DATA_W'($urandom);
            req = m;
            wait_gnt(ok, n, nd);
            if (!ok) begin n_chk++; $display("FAIL rnd_wait%0d got timeout want grant", t); end
            w = rr_pick(mptr, m);
            eg = '0; eg[w] = 1'b1; eb = dat[w];
            n_chk++; if (gnt !== eg || owner !== IDX_W'(w)) $display("FAIL rnd_gnt%0d got %b/%0d want %b/%0d", t, gnt, owner, eg, w); else n_pass++;
            n_chk++; if (tx_data !== eb) $display("FAIL rnd_data%0d got %h want %h", t, tx_data, eb); else n_pass++;
            req = '0;
            for (int r = 0; r < NREQ; r++) dat[r] = DATA_W'($urandom);
            wait_done(ok);
            if (!ok) begin n_chk++; $display("FAIL rnd_done%0d got timeout want done", t); end
            n_chk++; if (tx_data !== eb) $display("FAIL rnd_hold%0d got %h want %h", t, tx_data, eb); else n_pass++;
            mptr = (w + 1) % NREQ;
        end
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok; int n, nd, k, dn;
        do_reset();
        core_auto = 1'b0; man_busy = 1'b0;
        req = 4'b0001; dat[0] = DATA_W'($urandom); dat[1] = DATA_W'($urandom);
        wait_gnt(ok, n, nd);
        if (!ok) begin n_chk++; $display("FAIL t6_wait got timeout want grant"); end
        n_chk++; if (gnt !== 4'b0001) $display("FAIL t6_gnt got %b want 0001", gnt); else n_pass++;
        req = 4'b0011; k = 0; dn = 0; ok = 0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk); k++;
            if (done) dn++;
            if (err) ok = 1;
        end
        n_chk++; if (!ok || k != TIMEOUT_CYC + 1) $display("FAIL t6_err_time got %0d want %0d", k, TIMEOUT_CYC + 1); else n_pass++;
        n_chk++; if (dn != 0 || active !== 1'b0) $display("FAIL t6_no_done got %0d/%b want 0/0", dn, active); else n_pass++;
        wait_gnt(ok, n, nd);
        n_chk++; if (!ok || gnt !== 4'b0010) $display("FAIL t6_next got %b want 0010", gnt); else n_pass++;
        req = '0; ok = 0;
        for (int c = 0; c < 60 && !ok; c++) begin @(negedge clk); if (err) ok = 1; end
        core_auto = 1'b1;
    endtask
`endif

    task automatic test_invariants();
        repeat (2) @(negedge clk);
        n_chk++; if (bad != 0) $display("FAIL gnt_shape got %0d bad cycles want 0", bad); else n_pass++;
    endtask

    initial begin
        rst = 1'b0; req = '0; dat = '0;
        test_reset();
        test_round_robin();
        test_busy_block_and_hold();
        test_mid_reset();
        test_random();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
